// File: rtl/cdm16_bus_responder_if.sv
// cdm16 CPU bus bundle between the core (master) and a memory responder (slave).
//
// Signals:
//   address        byte address from CPU
//   mem            bus request active
//   data           0 = instruction space, 1 = data space
//   read           1 = read, 0 = write
//   word           1 = 16-bit access, 0 = byte access
//   data_out       CPU write data (byte writes use [7:0])
//   data_in        read data returned to CPU
//   in_hold        stall request to CPU
//   exc_trig_ext   bus-error trigger
//   direct_exc_vec bus-error vector
interface cdm16_bus_responder_if;
    logic [15:0] address;
    logic        mem;
    logic        data;
    logic        read;
    logic        word;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        in_hold;
    logic        exc_trig_ext;
    logic [5:0]  direct_exc_vec;

    modport master (
        output address, mem, data, read, word, data_out,
        input  data_in, in_hold, exc_trig_ext, direct_exc_vec
    );

    modport slave (
        input  address, mem, data, read, word, data_out,
        output data_in, in_hold, exc_trig_ext, direct_exc_vec
    );
endinterface

// File: rtl/cdm16_bus_responder.sv
// cdm16_bus_responder: memory-side responder for the cdm16 CPU bus.
// Holds separate instruction and data RAMs (16-bit words, little-endian,
// byte addressed), inserts WAIT_STATES cycles of in_hold per request and
// commits each write exactly once.
//
// Ports:
//   input_clock  sole clock, posedge active
//   rst          asynchronous, active-high reset
//   bus          cdm16_bus_responder_if.slave (request in, data_in/in_hold out)
//
// Parameters:
//   MEM_WORDS    words per space, power of two >= 2; addresses wrap modulo
//                2*MEM_WORDS unless bus errors are enabled
//   WAIT_STATES  0..15 posedges of in_hold per request
//   EXC_VEC      vector driven on direct_exc_vec for bus errors
//
// Optional feature: define CDM16_RESP_BUS_ERR_EN to flag out-of-range and
// misaligned word accesses as bus errors instead of wrapping/splitting.
module cdm16_bus_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [5:0]  EXC_VEC     = 6'd5
) (
    input logic                  input_clock,
    input logic                  rst,
    cdm16_bus_responder_if.slave bus
);
    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam logic        HAS_WAIT = (WAIT_STATES != 0);
    localparam logic [3:0]  CNT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [15:0] cap_addr;
    logic        cap_data;
    logic        cap_read;
    logic        cap_word;

    logic [15:0] imem [MEM_WORDS];
    logic [15:0] dmem [MEM_WORDS];

    logic        id_match;
    logic        accept;
    logic        req_err;
    logic        hold;
    logic        commit;
    logic        wait_last;
    logic [15:0] wr_addr;
    logic        wr_space;
    logic        wr_word;
    logic [15:0] rd_word;
    logic [15:0] rd_val;

`ifdef CDM16_RESP_BUS_ERR_EN
    logic cap_err;
    assign req_err = ({16'h0000, bus.address} >= 32'(2 * MEM_WORDS))
                   || (bus.word && bus.address[0]);
    assign bus.exc_trig_ext   = !rst && (state == S_DONE) && cap_err;
    assign bus.direct_exc_vec = bus.exc_trig_ext ? EXC_VEC : 6'd0;
`else
    assign req_err            = 1'b0;
    assign bus.exc_trig_ext   = 1'b0;
    assign bus.direct_exc_vec = 6'd0;
`endif

    assign id_match = (bus.address == cap_addr) && (bus.data == cap_data)
                   && (bus.read == cap_read) && (bus.word == cap_word);

    // A changed request seen in DONE is taken directly, exactly as IDLE would
    // take it; otherwise the CPU would see in_hold=0 for one cycle and treat
    // the new request as already complete.
    assign accept = bus.mem && ((state == S_IDLE) || ((state == S_DONE) && !id_match));

    assign wait_last = (state == S_WAIT) && bus.mem && (cnt == 4'd0);

    // in_hold covers the accept cycle plus every WAIT cycle but the last, so
    // the CPU samples it high on exactly WAIT_STATES posedges and completes
    // on the same posedge that commits the write.
    assign hold = !rst && ((accept && HAS_WAIT && !req_err)
                        || ((state == S_WAIT) && bus.mem && (cnt != 4'd0)));
    assign bus.in_hold = hold;

    // A zero-wait write commits from the live request; a waited write from
    // the captured one.
    assign commit = !rst && ((accept && !HAS_WAIT && !req_err && !bus.read)
                          || (wait_last && !cap_read));
    assign wr_addr  = (state == S_WAIT) ? cap_addr : bus.address;
    assign wr_space = (state == S_WAIT) ? cap_data : bus.data;
    assign wr_word  = (state == S_WAIT) ? cap_word : bus.word;

    // Read path: asynchronous array read. A word access at an odd address
    // falls through to the odd-lane byte path.
    // NOTE: every signal driven in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        rd_word = bus.data ? dmem[bus.address[AW:1]] : imem[bus.address[AW:1]];
        rd_val  = 16'h0000;
        if (bus.word && !bus.address[0])
            rd_val = rd_word;
        else if (bus.address[0])
            rd_val = {8'h00, rd_word[15:8]};
        else
            rd_val = {8'h00, rd_word[7:0]};
    end

    assign bus.data_in = (!rst && bus.mem && bus.read && !hold && !req_err) ? rd_val : 16'h0000;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge input_clock or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            cap_addr <= 16'h0000;
            cap_data <= 1'b0;
            cap_read <= 1'b0;
            cap_word <= 1'b0;
`ifdef CDM16_RESP_BUS_ERR_EN
            cap_err  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        cap_addr <= bus.address;
                        cap_data <= bus.data;
                        cap_read <= bus.read;
                        cap_word <= bus.word;
`ifdef CDM16_RESP_BUS_ERR_EN
                        cap_err  <= req_err;
`endif
                        if (req_err || !HAS_WAIT) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end else if (!bus.mem) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!bus.mem)
                        state <= S_IDLE;
                    else if (cnt == 4'd0)
                        state <= S_DONE;
                    else
                        cnt <= cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: RAM arrays carry no reset; contents survive rst and only the
    // commit strobe (already gated by rst) can change them.
    always_ff @(posedge input_clock) begin
        if (commit) begin
            if (wr_space) begin
                if (wr_word && !wr_addr[0])
                    dmem[wr_addr[AW:1]] <= bus.data_out;
                else if (wr_addr[0])
                    dmem[wr_addr[AW:1]][15:8] <= bus.data_out[7:0];
                else
                    dmem[wr_addr[AW:1]][7:0] <= bus.data_out[7:0];
            end else begin
                if (wr_word && !wr_addr[0])
                    imem[wr_addr[AW:1]] <= bus.data_out;
                else if (wr_addr[0])
                    imem[wr_addr[AW:1]][15:8] <= bus.data_out[7:0];
                else
                    imem[wr_addr[AW:1]][7:0] <= bus.data_out[7:0];
            end
        end
    end
endmodule

// File: tb/tb_cdm16_bus_responder.sv
// Self-checking bench for cdm16_bus_responder: one instance with two wait
// states and one with none. Drivers push expected responses into per-instance
// queues; monitors pop and compare whenever a request completes (mem=1 with
// in_hold=0 at the falling edge), then check the error outputs one cycle on.
module tb_cdm16_bus_responder;
    typedef struct {
        string       name;
        logic [15:0] data;
        int          hold;
        logic        exc;
    } exp_t;

    logic clk = 1'b0;
    logic rst2 = 1'b1;
    logic rst0 = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;

    exp_t q2[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    cdm16_bus_responder_if bus2();
    cdm16_bus_responder_if bus0();

    cdm16_bus_responder #(.MEM_WORDS(1024), .WAIT_STATES(2), .EXC_VEC(6'd5)) u_dut2 (
        .input_clock(clk),
        .rst        (rst2),
        .bus        (bus2.slave)
    );

    cdm16_bus_responder #(.MEM_WORDS(1024), .WAIT_STATES(0), .EXC_VEC(6'd5)) u_dut0 (
        .input_clock(clk),
        .rst        (rst0),
        .bus        (bus0.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor, two-wait-state instance.
    int   h2 = 0;
    bit   ep2 = 1'b0;
    exp_t cur2;
    always @(negedge clk) begin
        if (rst2) begin
            h2  = 0;
            ep2 = 1'b0;
        end else begin
            if (ep2) begin
                check({cur2.name, "/exc"}, 32'(bus2.exc_trig_ext), 32'(cur2.exc));
                check({cur2.name, "/vec"}, 32'(bus2.direct_exc_vec), cur2.exc ? 32'd5 : 32'd0);
                ep2 = 1'b0;
            end
            if (!bus2.mem) begin
                h2 = 0;
            end else if (bus2.in_hold) begin
                h2++;
            end else begin
                if (q2.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL ws2 unexpected completion at %0t", $time);
                end else begin
                    cur2 = q2.pop_front();
                    check({cur2.name, "/hold"}, 32'(h2), 32'(cur2.hold));
                    check({cur2.name, "/data"}, 32'(bus2.data_in), 32'(cur2.data));
                    ep2 = 1'b1;
                end
                h2 = 0;
            end
        end
    end

    // Monitor, zero-wait-state instance.
    int   h0 = 0;
    bit   ep0 = 1'b0;
    exp_t cur0;
    always @(negedge clk) begin
        if (rst0) begin
            h0  = 0;
            ep0 = 1'b0;
        end else begin
            if (ep0) begin
                check({cur0.name, "/exc"}, 32'(bus0.exc_trig_ext), 32'(cur0.exc));
                check({cur0.name, "/vec"}, 32'(bus0.direct_exc_vec), cur0.exc ? 32'd5 : 32'd0);
                ep0 = 1'b0;
            end
            if (!bus0.mem) begin
                h0 = 0;
            end else if (bus0.in_hold) begin
                h0++;
            end else begin
                if (q0.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL ws0 unexpected completion at %0t", $time);
                end else begin
                    cur0 = q0.pop_front();
                    check({cur0.name, "/hold"}, 32'(h0), 32'(cur0.hold));
                    check({cur0.name, "/data"}, 32'(bus0.data_in), 32'(cur0.data));
                    ep0 = 1'b1;
                end
                h0 = 0;
            end
        end
    end

    // Present one request, push its expected response, and return one time
    // step after the posedge that completes it (request still driven).
    task automatic op(input bit sel, input string name, input logic [15:0] a, input logic sp,
                      input logic rd, input logic wd, input logic [15:0] wdat,
                      input logic [15:0] exp_d, input int exp_h, input logic exp_e);
        exp_t e;
        bit   done;
        e = '{name: name, data: exp_d, hold: exp_h, exc: exp_e};
        done = 1'b0;
        if (sel) begin
            q2.push_back(e);
            bus2.address = a; bus2.data = sp; bus2.read = rd; bus2.word = wd;
            bus2.data_out = wdat; bus2.mem = 1'b1;
        end else begin
            q0.push_back(e);
            bus0.address = a; bus0.data = sp; bus0.read = rd; bus0.word = wd;
            bus0.data_out = wdat; bus0.mem = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(sel ? bus2.in_hold : bus0.in_hold)) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s/timeout: in_hold never dropped", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit sel, input int n);
        if (sel) bus2.mem = 1'b0;
        else     bus0.mem = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam bit WS2 = 1'b1;
    localparam bit WS0 = 1'b0;

    initial begin
        bus2.address = 16'h0; bus2.mem = 1'b0; bus2.data = 1'b0; bus2.read = 1'b0;
        bus2.word = 1'b0; bus2.data_out = 16'h0;
        bus0.address = 16'h0; bus0.mem = 1'b0; bus0.data = 1'b0; bus0.read = 1'b0;
        bus0.word = 1'b0; bus0.data_out = 16'h0;

        repeat (2) @(posedge clk);
        #1;
        check("reset/in_hold", 32'(bus2.in_hold), 32'd0);
        check("reset/data_in", 32'(bus2.data_in), 32'd0);
        rst2 = 1'b0;
        rst0 = 1'b0;
        @(posedge clk);
        #1;
        check("reset/exc", 32'(bus2.exc_trig_ext), 32'd0);
        check("reset/vec", 32'(bus2.direct_exc_vec), 32'd0);

        // Word write, readback, byte merge, byte reads.
        op(WS2, "wr_beef",   16'h0010, 1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h0000, 2, 1'b0);
        idle(WS2, 1);
        op(WS2, "rd_beef",   16'h0010, 1'b1, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 2, 1'b0);
        op(WS2, "wrb_5a",    16'h0011, 1'b1, 1'b0, 1'b0, 16'hA55A, 16'h0000, 2, 1'b0);
        op(WS2, "rd_5aef",   16'h0010, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h5AEF, 2, 1'b0);
        op(WS2, "rdb_odd",   16'h0011, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h005A, 2, 1'b0);
        op(WS2, "rdb_even",  16'h0010, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h00EF, 2, 1'b0);
        idle(WS2, 1);

        // Instruction and data spaces are independent.
        op(WS2, "iwr_1234",  16'h0010, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 2, 1'b0);
        op(WS2, "drd_keep",  16'h0010, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h5AEF, 2, 1'b0);
        op(WS2, "ird_1234",  16'h0010, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1234, 2, 1'b0);
        idle(WS2, 1);

        // Out-of-range read and misaligned word write.
        op(WS2, "wr_cafe",   16'h0000, 1'b1, 1'b0, 1'b1, 16'hCAFE, 16'h0000, 2, 1'b0);
        op(WS2, "wr_1122",   16'h0002, 1'b1, 1'b0, 1'b1, 16'h1122, 16'h0000, 2, 1'b0);
        idle(WS2, 1);
`ifdef CDM16_RESP_BUS_ERR_EN
        op(WS2, "rd_0800",   16'h0800, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 0, 1'b1);
        idle(WS2, 1);
        op(WS2, "wr_odd",    16'h0003, 1'b1, 1'b0, 1'b1, 16'h7777, 16'h0000, 0, 1'b1);
        idle(WS2, 1);
        op(WS2, "rd_0002",   16'h0002, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h1122, 2, 1'b0);
        op(WS2, "rd_0000",   16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 16'hCAFE, 2, 1'b0);
`else
        op(WS2, "rd_0800",   16'h0800, 1'b1, 1'b1, 1'b1, 16'h0000, 16'hCAFE, 2, 1'b0);
        idle(WS2, 1);
        op(WS2, "wr_odd",    16'h0003, 1'b1, 1'b0, 1'b1, 16'h7777, 16'h0000, 2, 1'b0);
        idle(WS2, 1);
        op(WS2, "rd_0002",   16'h0002, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h7722, 2, 1'b0);
`endif
        idle(WS2, 1);

        // mem dropped during WAIT: no write, in_hold low at once.
        op(WS2, "wr_4444",   16'h0030, 1'b1, 1'b0, 1'b1, 16'h4444, 16'h0000, 2, 1'b0);
        idle(WS2, 1);
        bus2.address = 16'h0030; bus2.data = 1'b1; bus2.read = 1'b0; bus2.word = 1'b1;
        bus2.data_out = 16'hDEAD; bus2.mem = 1'b1;
        @(posedge clk);
        #1;
        bus2.mem = 1'b0;
        #1;
        check("abort/in_hold", 32'(bus2.in_hold), 32'd0);
        idle(WS2, 2);
        op(WS2, "rd_4444",   16'h0030, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h4444, 2, 1'b0);
        idle(WS2, 1);

        // Reset during WAIT of a write: hold drops, write discarded.
        op(WS2, "wr_1111",   16'h0020, 1'b1, 1'b0, 1'b1, 16'h1111, 16'h0000, 2, 1'b0);
        idle(WS2, 1);
        bus2.address = 16'h0020; bus2.data = 1'b1; bus2.read = 1'b0; bus2.word = 1'b1;
        bus2.data_out = 16'hFFFF; bus2.mem = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid/hold_before", 32'(bus2.in_hold), 32'd1);
        rst2 = 1'b1;
        #1;
        check("rst_mid/in_hold", 32'(bus2.in_hold), 32'd0);
        check("rst_mid/data_in", 32'(bus2.data_in), 32'd0);
        bus2.mem = 1'b0;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        idle(WS2, 1);
        op(WS2, "rd_1111",   16'h0020, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h1111, 2, 1'b0);
        idle(WS2, 2);

        // Zero wait states: back-to-back, writes land on the first posedge.
        op(WS0, "z_wr_aaaa", 16'h0002, 1'b1, 1'b0, 1'b1, 16'hAAAA, 16'h0000, 0, 1'b0);
        op(WS0, "z_rd_aaaa", 16'h0002, 1'b1, 1'b1, 1'b1, 16'h0000, 16'hAAAA, 0, 1'b0);
        op(WS0, "z_wr_1357", 16'h0004, 1'b1, 1'b0, 1'b1, 16'h1357, 16'h0000, 0, 1'b0);
        op(WS0, "z_rd_1357", 16'h0004, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h1357, 0, 1'b0);
        op(WS0, "z_rdb_odd", 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0013, 0, 1'b0);
        idle(WS0, 3);

        if (q2.size() != 0 || q0.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL queue_drain: %0d/%0d responses never seen", q2.size(), q0.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
